// File: rtl/shenjing_pkg.sv
// shenjing_pkg -- shared types and helpers for the neuron partial-sum path.
//   DEF_* widths  : default weight/address/membrane widths and derived psum width
//   psum_t/vmem_t : signed partial-sum and membrane-potential types at defaults
//   state_t       : psum_neuron control states
//   sat13/satV    : clamp a wide signed value into psum/vmem range
package shenjing_pkg;

  localparam int DEF_WEIGHT_WIDTH = 5;
  localparam int DEF_ADDR_WIDTH   = 7;
  localparam int DEF_VMEM_WIDTH   = 16;
  // Accumulating 2^ADDR_WIDTH weights grows the sum by ADDR_WIDTH bits, plus one for the neighbour add.
  localparam int DEF_PSUM_WIDTH   = DEF_WEIGHT_WIDTH + DEF_ADDR_WIDTH + 1;

  typedef logic signed [DEF_PSUM_WIDTH-1:0] psum_t;
  typedef logic signed [DEF_VMEM_WIDTH-1:0] vmem_t;

  typedef enum logic [2:0] {IDLE, WAIT_IN, COMBINE, SEND, SPIKE} state_t;

  localparam int PSUM_MAX = 2**(DEF_PSUM_WIDTH-1) - 1;
  localparam int PSUM_MIN = -(2**(DEF_PSUM_WIDTH-1));
  localparam int VMEM_MAX = 2**(DEF_VMEM_WIDTH-1) - 1;
  localparam int VMEM_MIN = -(2**(DEF_VMEM_WIDTH-1));

  function automatic psum_t sat13(input int x);
    if (x > PSUM_MAX)      return psum_t'(PSUM_MAX);
    else if (x < PSUM_MIN) return psum_t'(PSUM_MIN);
    else                   return psum_t'(x);
  endfunction

  function automatic vmem_t satV(input int x);
    if (x > VMEM_MAX)      return vmem_t'(VMEM_MAX);
    else if (x < VMEM_MIN) return vmem_t'(VMEM_MIN);
    else                   return vmem_t'(x);
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add -- combinational signed saturating adder.
//   a  : signed AW-bit operand
//   b  : signed BW-bit operand
//   y  : a + b clamped to the signed OW-bit range (never wraps)
// The sum is formed one bit wider than the widest operand so it is exact
// before clamping; OW must not exceed that width.
module psum_sat_add #(
  parameter int AW = 13,
  parameter int BW = 13,
  parameter int OW = 13
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] y
);

  localparam int SW = ((AW > BW) ? AW : BW) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] sum;

  always_comb begin
    sum = SW'(a) + SW'(b);
    if (sum > MAXV)      y = OW'(MAXV);
    else if (sum < MINV) y = OW'(MINV);
    else                 y = OW'(sum);
  end

endmodule

// File: rtl/psum_neuron.sv
// psum_neuron -- consumer end of the per-neuron accumulator.
// Captures the finished partial sum on the falling edge of start, optionally
// adds the upstream neighbour's sum, then forwards it downstream (last=0) or
// integrates it into a saturating membrane potential and fires (last=1).
// Ports:
//   clk, rstb                      : clock, async active-low reset (sync release)
//   start, psum_local              : accumulation window and running sum
//   use_in, last                   : static config while busy
//   psum_in_valid/ready, psum_in   : neighbour partial-sum link
//   psum_out_valid/ready, psum_out : forwarded partial-sum link
//   threshold                      : signed firing threshold
//   spike_valid/ready              : spike event link
//   vmem                           : registered membrane potential
//   overrun                        : sticky, window ended while busy
//   leak                           : only with PSUM_NEURON_LEAK_EN, unsigned per-update leak
module psum_neuron
  import shenjing_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int VMEM_WIDTH   = DEF_VMEM_WIDTH,
  localparam int PSUM_WIDTH  = WEIGHT_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         start,
  input  logic signed [PSUM_WIDTH-1:0] psum_local,
  input  logic                         use_in,
  input  logic                         last,
  input  logic                         psum_in_valid,
  output logic                         psum_in_ready,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic                         psum_out_valid,
  input  logic                         psum_out_ready,
  output logic signed [PSUM_WIDTH-1:0] psum_out,
  input  logic signed [VMEM_WIDTH-1:0] threshold,
`ifdef PSUM_NEURON_LEAK_EN
  input  logic        [VMEM_WIDTH-1:0] leak,
`endif
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic signed [VMEM_WIDTH-1:0] vmem,
  output logic                         overrun
);

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t state, state_n;
  logic   start_q;
  logic   cap;
  logic   hs_in;
  logic   fire;

  logic signed [PSUM_WIDTH-1:0] acc_r;
  logic signed [PSUM_WIDTH-1:0] nb_sum;
  logic signed [VMEM_WIDTH+1:0] vm_addend;
  logic signed [VMEM_WIDTH-1:0] v_sum;

  // psum_local still holds the final sum on the edge where start drops.
  assign cap   = start_q & ~start;
  assign hs_in = psum_in_valid & psum_in_ready;
  assign fire  = (v_sum >= threshold);

  psum_sat_add #(.AW(PSUM_WIDTH), .BW(PSUM_WIDTH), .OW(PSUM_WIDTH)) u_nb_add (
    .a (acc_r),
    .b (psum_in),
    .y (nb_sum)
  );

  // Two extra bits keep acc_r - leak exact before the single saturation step.
  always_comb begin
`ifdef PSUM_NEURON_LEAK_EN
    vm_addend = (VMEM_WIDTH+2)'(acc_r) - $signed({2'b00, leak});
`else
    vm_addend = (VMEM_WIDTH+2)'(acc_r);
`endif
  end

  psum_sat_add #(.AW(VMEM_WIDTH), .BW(VMEM_WIDTH+2), .OW(VMEM_WIDTH)) u_vm_add (
    .a (vmem),
    .b (vm_addend),
    .y (v_sum)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cap) state_n = use_in ? WAIT_IN : COMBINE;
      WAIT_IN: if (hs_in) state_n = COMBINE;
      COMBINE: begin
        if (!last)     state_n = SEND;
        else if (fire) state_n = SPIKE;
        else           state_n = IDLE;
      end
      SEND:    if (psum_out_ready) state_n = IDLE;
      SPIKE:   if (spike_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      acc_r          <= '0;
      psum_out       <= '0;
      vmem           <= '0;
      overrun        <= 1'b0;
      psum_in_ready  <= 1'b0;
      psum_out_valid <= 1'b0;
      spike_valid    <= 1'b0;
    end else begin
      state          <= state_n;
      start_q        <= start;
      // Handshake outputs are registered copies of the state being entered.
      psum_in_ready  <= (state_n == WAIT_IN);
      psum_out_valid <= (state_n == SEND);
      spike_valid    <= (state_n == SPIKE);

      if (state == IDLE && cap)     acc_r <= psum_local;
      if (state == WAIT_IN && hs_in) acc_r <= nb_sum;

      if (state == COMBINE) begin
        if (!last)     psum_out <= acc_r;
        else if (fire) vmem     <= '0;
        else           vmem     <= v_sum;
      end

      // A window ending while busy is dropped; this includes the edge that
      // completes a SEND/SPIKE handshake.
      if (cap && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule
